// File: rtl/logic32_arbiter_if.sv
// Request, response and shared logic-unit signals of the two-requester logic arbiter.
interface logic32_arbiter_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
);
   logic             req0_valid;
   logic             req0_ready;
   logic [1:0]       req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic [1:0]       req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             rsp0_valid;
   logic             rsp0_ready;
   logic [WIDTH-1:0] rsp0_y;
   logic             rsp1_valid;
   logic             rsp1_ready;
   logic [WIDTH-1:0] rsp1_y;
   logic [1:0]       lu_op;
   logic [WIDTH-1:0] lu_a;
   logic [WIDTH-1:0] lu_b;
   logic [WIDTH-1:0] lu_y;
   logic             busy;
   logic [CNT_W-1:0] op_cnt;

   // Arbiter side
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp0_ready, rsp1_ready, lu_y,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_y, rsp1_valid, rsp1_y,
      output lu_op, lu_a, lu_b, busy, op_cnt
   );

   // Requesters and logic unit side
   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp0_ready, rsp1_ready, lu_y,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_y, rsp1_valid, rsp1_y,
      input  lu_op, lu_a, lu_b, busy, op_cnt
   );
endinterface

// File: rtl/logic32_arbiter.sv
// Round-robin arbiter sharing one combinational AND/OR/NOR/NOT unit between two requesters.
module logic32_arbiter #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned PRIO_INIT = 0,
   parameter int unsigned CNT_W     = 16
) (
   input logic                clk,
   input logic                rst_n,
   logic32_arbiter_if.slave   bus
);
   localparam logic [1:0] OP_NOT = 2'b11;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_q, state_d;
   logic             prio_q;
   logic             owner_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] y0_q;
   logic [WIDTH-1:0] y1_q;
   logic [CNT_W-1:0] cnt_q;

   logic grant0, grant1, capture, done;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state, grant and phase strobes
   always_comb begin
      state_d = state_q;
      grant0  = 1'b0;
      grant1  = 1'b0;
      capture = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            grant0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
            grant1 = bus.req1_valid && (!bus.req0_valid ||  prio_q);
            if (grant0 || grant1) state_d = EXEC;
         end
         EXEC: begin
            capture = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            done = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
            if (done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request latch, result capture, priority rotation and completion count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q  <= 1'(PRIO_INIT);
         owner_q <= 1'b0;
         op_q    <= 2'b00;
         a_q     <= '0;
         b_q     <= '0;
         y0_q    <= '0;
         y1_q    <= '0;
         cnt_q   <= '0;
      end else begin
         if (grant0 || grant1) begin
            owner_q <= grant1;
            op_q    <= grant1 ? bus.req1_op : bus.req0_op;
            a_q     <= grant1 ? bus.req1_a  : bus.req0_a;
            if ((grant1 ? bus.req1_op : bus.req0_op) == OP_NOT) b_q <= '0;
            else                                                b_q <= grant1 ? bus.req1_b : bus.req0_b;
         end
         if (capture) begin
            if (owner_q) y1_q <= bus.lu_y;
            else         y0_q <= bus.lu_y;
         end
         if (done) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            prio_q <= ~owner_q;
         end
      end
   end

   // Ready is the only path from inputs; held low while reset is asserted
   assign bus.req0_ready = rst_n && grant0;
   assign bus.req1_ready = rst_n && grant1;

   // Outputs decoded from registered state
   assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
   assign bus.rsp1_valid = (state_q == RESP) &&  owner_q;
   assign bus.rsp0_y     = y0_q;
   assign bus.rsp1_y     = y1_q;
   assign bus.lu_op      = op_q;
   assign bus.lu_a       = a_q;
   assign bus.lu_b       = b_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.op_cnt     = cnt_q;
endmodule

// File: tb/tb_logic32_arbiter.sv
// Bench for logic32_arbiter: vector table plus hand-written timing, backpressure, reset and wrap sequences.
module tb_logic32_arbiter;
   localparam int unsigned W  = 32;
   localparam int unsigned CW = 4;

   typedef struct {
      logic        r;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   nchk = 0;
   int   nerr = 0;

   logic32_arbiter_if #(.WIDTH(W), .CNT_W(CW)) bus ();

   logic32_arbiter #(.WIDTH(W), .PRIO_INIT(0), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Shared logic unit: gate bank selected by lu_op
   assign bus.lu_y = (bus.lu_op == 2'b00) ? (bus.lu_a & bus.lu_b) :
                     (bus.lu_op == 2'b01) ? (bus.lu_a | bus.lu_b) :
                     (bus.lu_op == 2'b10) ? ~(bus.lu_a | bus.lu_b) : ~bus.lu_a;

   vec_t        q0[$], q1[$];
   logic [31:0] exp0[$], exp1[$];
   int          glog_r[$], glog_c[$];
   vec_t        tbl[6];

   function automatic logic [31:0] ref_y(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         2'b00:   ref_y = a & b;
         2'b01:   ref_y = a | b;
         2'b10:   ref_y = ~a & ~b;
         default: ref_y = ~a;
      endcase
   endfunction

   function automatic vec_t rnd_vec(input logic r);
      vec_t v;
      v.r  = r;
      v.op = 2'($urandom_range(0, 3));
      v.a  = $urandom;
      v.b  = $urandom;
      v.y  = ref_y(v.op, v.a, v.b);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic load_heads();
      if (q0.size() != 0) begin
         bus.req0_valid = 1'b1; bus.req0_op = q0[0].op; bus.req0_a = q0[0].a; bus.req0_b = q0[0].b;
      end else bus.req0_valid = 1'b0;
      if (q1.size() != 0) begin
         bus.req1_valid = 1'b1; bus.req1_op = q1[0].op; bus.req1_a = q1[0].a; bus.req1_b = q1[0].b;
      end else bus.req1_valid = 1'b0;
   endtask

   // Drive queued ops on both requesters; scoreboard responses; check unit drive in EXEC
   task automatic run_ops(input int budget);
      int   cyc = 0;
      bit   adv;
      vec_t gv;
      load_heads();
      while (q0.size() + q1.size() + exp0.size() + exp1.size() != 0) begin
         @(negedge clk);
         cyc++;
         adv = 1'b0;
         if (bus.req0_valid && bus.req0_ready) begin
            gv = q0.pop_front(); exp0.push_back(gv.y); adv = 1'b1;
            glog_r.push_back(0); glog_c.push_back(cyc);
         end
         if (bus.req1_valid && bus.req1_ready) begin
            gv = q1.pop_front(); exp1.push_back(gv.y); adv = 1'b1;
            glog_r.push_back(1); glog_c.push_back(cyc);
         end
         if (bus.rsp0_valid && bus.rsp0_ready) begin
            if (exp0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
            else                  chk("rsp0_y", bus.rsp0_y, exp0.pop_front());
         end
         if (bus.rsp1_valid && bus.rsp1_ready) begin
            if (exp1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
            else                  chk("rsp1_y", bus.rsp1_y, exp1.pop_front());
         end
         @(posedge clk); #1;
         load_heads();
         if (adv) begin
            chk("exec_busy", 32'(bus.busy), 32'd1);
            chk("exec_lu_op", 32'(bus.lu_op), 32'(gv.op));
            chk("exec_lu_a", bus.lu_a, gv.a);
            chk("exec_lu_b", bus.lu_b, (gv.op == 2'b11) ? 32'd0 : gv.b);
         end
         if (cyc > budget) begin
            chk("run_ops_timeout", 32'(cyc), 32'(budget));
            q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
            clear_inputs();
         end
      end
   endtask

   initial begin
      logic [31:0] held;
      int          nv;

      tbl[0] = '{r: 1'b1, op: 2'b11, a: 32'h0000_0000, b: 32'h1234_5678, y: 32'hFFFF_FFFF};
      tbl[1] = '{r: 1'b1, op: 2'b10, a: 32'h0000_0001, b: 32'h0000_0002, y: 32'hFFFF_FFFC};
      tbl[2] = '{r: 1'b0, op: 2'b01, a: 32'hF0F0_F0F0, b: 32'h0000_FFFF, y: 32'hF0F0_FFFF};
      tbl[3] = '{r: 1'b1, op: 2'b00, a: 32'hDEAD_BEEF, b: 32'hFFFF_0000, y: 32'hDEAD_0000};
      tbl[4] = '{r: 1'b0, op: 2'b11, a: 32'hA5A5_A5A5, b: 32'hFFFF_FFFF, y: 32'h5A5A_5A5A};
      tbl[5] = '{r: 1'b0, op: 2'b10, a: 32'h0000_0000, b: 32'h0000_0000, y: 32'hFFFF_FFFF};

      // Reset state
      do_reset();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_op_cnt", 32'(bus.op_cnt), 32'd0);
      chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
      chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
      chk("rst_lu_op", 32'(bus.lu_op), 32'd0);
      chk("rst_lu_a", bus.lu_a, 32'd0);
      chk("rst_rsp0_y", bus.rsp0_y, 32'd0);

      // Single AND on req0, cycle by cycle
      bus.req0_valid = 1'b1; bus.req0_op = 2'b00;
      bus.req0_a = 32'hFFFF_0000; bus.req0_b = 32'h0F0F_0F0F;
      #1 chk("c0_req0_ready", 32'(bus.req0_ready), 32'd1);
      chk("c0_req1_ready", 32'(bus.req1_ready), 32'd0);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      chk("c1_busy", 32'(bus.busy), 32'd1);
      chk("c1_lu_op", 32'(bus.lu_op), 32'd0);
      chk("c1_lu_b", bus.lu_b, 32'h0F0F_0F0F);
      chk("c1_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
      @(posedge clk); #1;
      chk("c2_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
      chk("c2_rsp0_y", bus.rsp0_y, 32'h0F0F_0000);
      chk("c2_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
      @(posedge clk); #1;
      chk("c3_op_cnt", 32'(bus.op_cnt), 32'd1);
      chk("c3_busy", 32'(bus.busy), 32'd0);
      chk("c3_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);

      // Vector table, one op at a time through the scoreboard
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].r) q1.push_back(tbl[i]);
         else          q0.push_back(tbl[i]);
         run_ops(20);
      end
      chk("tbl_op_cnt", 32'(bus.op_cnt), 32'd7);

      // Contention: both valid right out of reset
      do_reset();
      glog_r.delete(); glog_c.delete();
      for (int i = 0; i < 2; i++) begin
         q0.push_back(rnd_vec(1'b0));
         q1.push_back(rnd_vec(1'b1));
      end
      run_ops(60);
      chk("cont_grants", 32'(glog_r.size()), 32'd4);
      if (glog_r.size() == 4) begin
         for (int i = 0; i < 4; i++) chk("cont_order", 32'(glog_r[i]), 32'(i % 2));
         for (int i = 1; i < 4; i++) chk("cont_gap", 32'(glog_c[i] - glog_c[i-1]), 32'd3);
      end
      chk("cont_op_cnt", 32'(bus.op_cnt), 32'd4);

      // Response backpressure on req0 while req1 waits
      do_reset();
      bus.rsp0_ready = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_op = 2'b01; bus.req0_a = 32'h1200_0034; bus.req0_b = 32'h0056_7800;
      bus.req1_valid = 1'b1; bus.req1_op = 2'b00; bus.req1_a = 32'hCAFE_F00D; bus.req1_b = 32'h0F0F_FFFF;
      #1 chk("bp_req0_ready", 32'(bus.req0_ready), 32'd1);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      @(posedge clk); #1;
      held = bus.rsp0_y;
      chk("bp_rsp0_y", held, 32'h1256_7834);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(bus.rsp0_valid), 32'd1);
         chk("bp_hold_y", bus.rsp0_y, held);
         chk("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
      end
      @(posedge clk); #1;
      bus.rsp0_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_busy", 32'(bus.busy), 32'd0);
      chk("bp_req1_grant", 32'(bus.req1_ready), 32'd1);
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
      chk("bp_rsp1_y", bus.rsp1_y, 32'h0A0E_F00D);
      @(posedge clk); #1;
      chk("bp_op_cnt", 32'(bus.op_cnt), 32'd2);

      // Asynchronous reset during EXEC
      bus.req0_valid = 1'b1; bus.req0_op = 2'b11; bus.req0_a = 32'h0000_FFFF; bus.req0_b = 32'h1;
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      chk("mid_busy_before", 32'(bus.busy), 32'd1);
      #2 rst_n = 1'b0;
      bus.req1_valid = 1'b1;
      #1;
      chk("mid_busy", 32'(bus.busy), 32'd0);
      chk("mid_lu_op", 32'(bus.lu_op), 32'd0);
      chk("mid_lu_a", bus.lu_a, 32'd0);
      chk("mid_rsp0_y", bus.rsp0_y, 32'd0);
      chk("mid_rsp1_y", bus.rsp1_y, 32'd0);
      chk("mid_op_cnt", 32'(bus.op_cnt), 32'd0);
      chk("mid_req1_ready", 32'(bus.req1_ready), 32'd0);
      chk("mid_rsp_valid", 32'(bus.rsp0_valid | bus.rsp1_valid), 32'd0);
      bus.req1_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      nv = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.rsp0_valid || bus.rsp1_valid) nv++;
      end
      chk("mid_no_rsp", 32'(nv), 32'd0);
      @(posedge clk); #1;

      // Counter wrap: 17 ops on a 4-bit counter
      for (int i = 0; i < 9; i++) q0.push_back(rnd_vec(1'b0));
      for (int i = 0; i < 8; i++) q1.push_back(rnd_vec(1'b1));
      run_ops(200);
      chk("wrap_op_cnt", 32'(bus.op_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/logic32_arbiter.md
Name: logic32_arbiter

Overview:
- Shares one 32-bit combinational logic unit (AND/OR/NOR/NOT gate bank) between two requesters.
- Round-robin arbitration with valid/ready request handshake.
- Drives the unit's op select and operands, captures its result, and returns it on a per-requester response handshake.
- Sits between the two issuing datapaths and the shared logic unit.

Parameters:
- WIDTH, 32, operand/result width.
- PRIO_INIT, 0, requester holding priority after reset (0 or 1).
- CNT_W, 16, width of completed-operation counter.

Ports:
- CLK  input  1  clock, rising edge.
- RSTN  input  1  asynchronous active-low reset.
- REQ0_VALID  input  1  requester 0 has an operation.
- REQ0_READY  output  1  requester 0 request accepted this cycle.
- REQ0_OP  input  2  op code: 00 AND, 01 OR, 10 NOR, 11 NOT(A).
- REQ0_A  input  WIDTH  operand A.
- REQ0_B  input  WIDTH  operand B (ignored for NOT).
- REQ1_VALID, REQ1_READY, REQ1_OP, REQ1_A, REQ1_B: same as requester 0, for requester 1.
- RSP0_VALID  output  1  result for requester 0 available.
- RSP0_READY  input  1  requester 0 takes result.
- RSP0_Y  output  WIDTH  result for requester 0.
- RSP1_VALID, RSP1_READY, RSP1_Y: same as requester 0, for requester 1.
- LU_OP  output  2  op select to shared logic unit.
- LU_A  output  WIDTH  operand A to logic unit.
- LU_B  output  WIDTH  operand B to logic unit (0 for NOT).
- LU_Y  input  WIDTH  combinational result from logic unit.
- BUSY  output  1  state is not IDLE.
- OP_CNT  output  CNT_W  completed operations, wraps modulo 2^CNT_W.

Behaviour:
- One clock (CLK), asynchronous active-low reset (RSTN).
- Reset (asynchronous, RSTN low):
  - state=IDLE; priority pointer=PRIO_INIT; owner=0.
  - Operand, op and result registers=0; OP_CNT=0.
  - All READY/VALID outputs=0; LU_OP/LU_A/LU_B=0; RSPn_Y=0; BUSY=0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational.
    - Only one VALID: grant that requester.
    - Both VALID: grant the priority pointer.
    - Neither: no grant.
  - REQn_READY=1 only for the granted requester, only in IDLE.
  - Transfer on VALID&&READY: latch OP, A and B (B forced to 0 when OP=11); owner=n; next state EXEC.
  - No transfer: remain IDLE.
- EXEC (exactly 1 cycle):
  - LU_OP/LU_A/LU_B are driven from the registers; they are stable from EXEC through end of RESP.
  - At the rising edge ending EXEC, the result register captures LU_Y; next state RESP.
- RESP:
  - RSP[owner]_VALID=1 and RSP[owner]_Y=result register; the other RSP_VALID=0.
  - VALID and data hold until RSP[owner]_READY=1.
  - On that edge:
    - OP_CNT increments, wrapping from all-ones to 0.
    - Priority pointer becomes the non-owner.
    - Next state IDLE.
  - RSP_READY for a non-owner is ignored.
- Latency: request transfer edge → RSP_VALID high 2 cycles later. Maximum throughput is 1 op per 3 cycles with RSP_READY tied high.
- RSPn_Y holds its last result when RSPn_VALID=0; it is updated only on that requester's capture.
- Requests arriving in EXEC or RESP see READY=0 and must hold VALID. No request is dropped or reordered.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- A requester is never starved more than one operation.
- BUSY=1 in EXEC and RESP.
- Reset mid-operation: the in-flight operation is discarded, no response is issued, and OP_CNT returns to 0.
- All outputs except REQn_READY are registered or decoded from registered state only. REQn_READY additionally depends on REQn_VALID.

Test Plan:
- Single op, req0 AND:
  - Stimulus: A=0xFFFF0000, B=0x0F0F0F0F, RSP0_READY=1, LU modelled from the 32-bit gates.
  - Response: REQ0_READY at cycle 0; LU_OP=00 at cycle 1; RSP0_VALID=1 with RSP0_Y=0x0F0F0000 at cycle 2; OP_CNT=1.
- NOT and NOR on req1:
  - NOT A=0x00000000 → RSP1_Y=0xFFFFFFFF, LU_B=0.
  - NOR A=0x1, B=0x2 → RSP1_Y=0xFFFFFFFC.
- Contention:
  - Stimulus: both requesters valid from reset, PRIO_INIT=0, RSP_READY high.
  - Response: grant order 0,1,0,1 over 4 ops; a new grant every 3 cycles; OP_CNT=4.
- Response backpressure:
  - Stimulus: RSP0_READY low for 5 cycles while REQ1_VALID=1.
  - Response: RSP0_VALID and RSP0_Y stable all 5 cycles; REQ1_READY=0 throughout; req1 granted in the first IDLE cycle after RSP0_READY rises.
- Reset mid-op:
  - Stimulus: RSTN asserted asynchronously during EXEC.
  - Response: all outputs 0 immediately, with no clock edge required; after release, no RSP_VALID occurs without a new request.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 ops.
  - Response: OP_CNT=1.
